controller_poll_scheduler: RTL and testbench



---
 rtl/controller_poll_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_controller_poll_scheduler.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/controller_poll_scheduler.sv
// controller_poll_scheduler
//   Drives the 6-button pad reader and turns its latched word into game events.
//   Every POLL_PERIOD cycles it pulses poll_flag for 2 cycles, waits READ_WAIT
//   cycles for the reader's read window, then samples pad_state. It debounces
//   the sampled word across polls and emits one-cycle press events. Held D-pad
//   keys also auto-repeat.
//
// Ports:
//   clock      in   system clock, all logic on posedge
//   reset      in   synchronous active-low reset
//   enable     in   polling enable
//   pad_state  in   [11:0] reader word, 1 = pressed, bit11 unused
//   poll_flag  out  start-read flag to the reader
//   pad_stable out  [11:0] debounced pad word, bit11 always 0
//   pad_press  out  [11:0] one-cycle pulse per new press or auto-repeat
//   pad_valid  out  one-cycle pulse per completed poll
//   busy       out  high while a poll is in progress
module controller_poll_scheduler #(
    parameter int unsigned POLL_PERIOD    = 833333,
    parameter int unsigned READ_WAIT      = 8100,
    parameter int unsigned DEBOUNCE_COUNT = 3,
    parameter int unsigned REPEAT_DELAY   = 30,
    parameter int unsigned REPEAT_RATE    = 6,
    parameter logic [11:0] REPEAT_MASK    = 12'h780
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [11:0] pad_state,
    output logic        poll_flag,
    output logic [11:0] pad_stable,
    output logic [11:0] pad_press,
    output logic        pad_valid,
    output logic        busy
);

    localparam int PW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam int WW = $clog2(READ_WAIT + 2);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TRIGGER,
        ST_WAIT,
        ST_SAMPLE
    } state_t;

    state_t      state_q, state_d;
    logic [PW-1:0] period_cnt_q, period_cnt_d;
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic [11:0] cand_q, cand_d;
    logic [3:0]  match_q, match_d;
    logic [7:0]  rep_cnt_q, rep_cnt_d;
    logic        rep_armed_q, rep_armed_d;
    logic [11:0] stable_q, stable_d;
    logic [11:0] press_q, press_d;
    logic        valid_q, valid_d;

    // SAMPLE-state scratch values
    logic [11:0] sample;
    logic [11:0] new_stable;
    logic [11:0] press_edge;
    logic [11:0] rep;
    logic [7:0]  rep_cnt_inc;

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        cand_d      = cand_q;
        match_d     = match_q;
        rep_cnt_d   = rep_cnt_q;
        rep_armed_d = rep_armed_q;
        stable_d    = stable_q;
        press_d     = '0;
        valid_d     = 1'b0;
        sample      = pad_state & 12'h7FF;
        new_stable  = stable_q;
        press_edge  = '0;
        rep         = '0;
        rep_cnt_inc = rep_cnt_q + 8'd1;

        // Free-running poll period; held at 0 while disabled so the first
        // poll fires the cycle after enable rises.
        if (!enable)
            period_cnt_d = '0;
        else if (period_cnt_q == PW'(POLL_PERIOD - 1))
            period_cnt_d = '0;
        else
            period_cnt_d = period_cnt_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                wait_cnt_d = '0;
                if (enable && period_cnt_q == '0)
                    state_d = ST_TRIGGER;
            end
            ST_TRIGGER: begin
                // wait_cnt doubles as the 2-cycle flag timer
                if (wait_cnt_q == WW'(1)) begin
                    wait_cnt_d = '0;
                    state_d    = ST_WAIT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == WW'(READ_WAIT - 1)) begin
                    wait_cnt_d = '0;
                    state_d    = ST_SAMPLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_SAMPLE: begin
                state_d = ST_IDLE;
                valid_d = 1'b1;

                // Debounce: count consecutive identical samples
                if (sample == cand_q) begin
                    if (match_q < 4'(DEBOUNCE_COUNT))
                        match_d = match_q + 4'd1;
                end else begin
                    cand_d  = sample;
                    match_d = 4'd1;
                end
                if (match_d == 4'(DEBOUNCE_COUNT))
                    new_stable = cand_d;
                stable_d   = new_stable;
                press_edge = new_stable & ~stable_q;

                // Auto-repeat runs only while the masked set is unchanged
                if ((new_stable & REPEAT_MASK) == '0 ||
                    (new_stable & REPEAT_MASK) != (stable_q & REPEAT_MASK)) begin
                    rep_cnt_d   = '0;
                    rep_armed_d = 1'b0;
                end else if (!rep_armed_q && rep_cnt_inc == 8'(REPEAT_DELAY)) begin
                    rep         = new_stable & REPEAT_MASK;
                    rep_armed_d = 1'b1;
                    rep_cnt_d   = '0;
                end else if (rep_armed_q && rep_cnt_inc == 8'(REPEAT_RATE)) begin
                    rep       = new_stable & REPEAT_MASK;
                    rep_cnt_d = '0;
                end else begin
                    rep_cnt_d = rep_cnt_inc;
                end

                press_d = press_edge | rep;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            period_cnt_q <= '0;
            wait_cnt_q   <= '0;
            cand_q       <= '0;
            match_q      <= '0;
            rep_cnt_q    <= '0;
            rep_armed_q  <= 1'b0;
            stable_q     <= '0;
            press_q      <= '0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            period_cnt_q <= period_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            cand_q       <= cand_d;
            match_q      <= match_d;
            rep_cnt_q    <= rep_cnt_d;
            rep_armed_q  <= rep_armed_d;
            stable_q     <= stable_d;
            press_q      <= press_d;
            valid_q      <= valid_d;
        end
    end

    assign poll_flag  = (state_q == ST_TRIGGER);
    assign busy       = (state_q != ST_IDLE);
    assign pad_stable = stable_q;
    assign pad_press  = press_q;
    assign pad_valid  = valid_q;

endmodule

// File: tb/tb_controller_poll_scheduler.sv
module tb_controller_poll_scheduler;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [11:0] pad_state;
    logic        poll_flag;
    logic [11:0] pad_stable;
    logic [11:0] pad_press;
    logic        pad_valid;
    logic        busy;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    controller_poll_scheduler #(
        .POLL_PERIOD(100),
        .READ_WAIT(20),
        .DEBOUNCE_COUNT(3),
        .REPEAT_DELAY(4),
        .REPEAT_RATE(2),
        .REPEAT_MASK(12'h780)
    ) dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .pad_state(pad_state),
        .poll_flag(poll_flag),
        .pad_stable(pad_stable),
        .pad_press(pad_press),
        .pad_valid(pad_valid),
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Wait (bounded) for pad_valid, check press/stable, then check the pulse is one cycle
    task automatic poll_chk(input string tag, input int p,
                            input logic [11:0] exp_press, input logic [11:0] exp_stable);
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (pad_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk($sformatf("%s_p%0d_seen", tag, p), 32'(ok), 32'd1);
        chk($sformatf("%s_p%0d_press", tag, p), 32'(pad_press), 32'(exp_press));
        chk($sformatf("%s_p%0d_stable", tag, p), 32'(pad_stable), 32'(exp_stable));
        @(negedge clock);
        chk($sformatf("%s_p%0d_pulse", tag, p), {30'd0, pad_valid, |pad_press}, 32'd0);
    endtask

    task automatic start_run(input logic [11:0] pad);
        reset  = 1'b0;
        enable = 1'b0;
        repeat (2) @(negedge clock);
        pad_state = pad;
        reset     = 1'b1;
        enable    = 1'b1;
    endtask

    initial begin
        reset     = 1'b0;
        enable    = 1'b0;
        pad_state = 12'h000;

        // 1. reset state and poll timing
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk($sformatf("rst_outs_%0d", k),
                {15'd0, poll_flag, pad_valid, busy, pad_stable, pad_press[0]}, 32'd0);
            chk($sformatf("rst_press_%0d", k), 32'(pad_press), 32'd0);
        end
        reset = 1'b1;
        @(negedge clock);
        chk("idle_disabled", {30'd0, poll_flag, busy}, 32'd0);
        enable = 1'b1;
        for (int k = 1; k <= 101; k++) begin
            @(negedge clock);
            case (k)
                1:   chk("t1_flag", {30'd0, poll_flag, busy}, 32'd3);
                2:   chk("t2_flag", 32'(poll_flag), 32'd1);
                3:   chk("t3_flag", {30'd0, poll_flag, busy}, 32'd1);
                23:  chk("t23_valid", {30'd0, pad_valid, busy}, 32'd1);
                24:  chk("t24_valid", {30'd0, pad_valid, busy}, 32'd2);
                25:  chk("t25_valid", 32'(pad_valid), 32'd0);
                100: chk("t100_flag", 32'(poll_flag), 32'd0);
                101: chk("t101_flag", 32'(poll_flag), 32'd1);
                default: ;
            endcase
        end

        // 2. button a held: accepted at poll 3, single press
        start_run(12'h040);
        for (int p = 1; p <= 6; p++)
            poll_chk("hold_a", p, (p == 3) ? 12'h040 : 12'h000,
                     (p >= 3) ? 12'h040 : 12'h000);

        // 3. one-poll glitch never accepted
        start_run(12'h040);
        poll_chk("glitch", 1, 12'h000, 12'h000);
        pad_state = 12'h000;
        for (int p = 2; p <= 5; p++)
            poll_chk("glitch", p, 12'h000, 12'h000);

        // 4. up held: edge at 3, repeats at 7, 9, 11, 13
        start_run(12'h400);
        for (int p = 1; p <= 13; p++)
            poll_chk("rep_up", p,
                     (p == 3 || p == 7 || p == 9 || p == 11 || p == 13) ? 12'h400 : 12'h000,
                     (p >= 3) ? 12'h400 : 12'h000);

        // 5. start added at poll 5: its edge merges with up's first repeat
        start_run(12'h400);
        for (int p = 1; p <= 7; p++) begin
            if (p == 5) pad_state = 12'h401;
            poll_chk("merge", p,
                     (p == 3) ? 12'h400 : (p == 7) ? 12'h401 : 12'h000,
                     (p == 7) ? 12'h401 : (p >= 3) ? 12'h400 : 12'h000);
        end

        // 6. reset during WAIT aborts the poll
        begin
            bit seen = 1'b0;
            bit vld  = 1'b0;
            for (int i = 0; i < 200; i++) begin
                @(negedge clock);
                if (poll_flag) begin
                    seen = 1'b1;
                    break;
                end
            end
            chk("mid_trigger_seen", 32'(seen), 32'd1);
            repeat (10) @(negedge clock);
            chk("mid_in_wait", {30'd0, poll_flag, busy}, 32'd1);
            reset = 1'b0;
            @(negedge clock);
            chk("mid_rst_outs", {29'd0, poll_flag, pad_valid, busy}, 32'd0);
            chk("mid_rst_stable", 32'(pad_stable), 32'd0);
            for (int i = 0; i < 30; i++) begin
                @(negedge clock);
                if (pad_valid) vld = 1'b1;
            end
            chk("mid_no_valid", 32'(vld), 32'd0);
            reset = 1'b1;
            @(negedge clock);
            chk("mid_restart_flag", 32'(poll_flag), 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
